// File: rtl/mult30x30_pipeline_pkg.sv
// Shared widths, latencies and modulus constants for the 30x30 multiplier
// feeding the 60-bit windowed modular reducer.
package mult30x30_pipeline_pkg;

    localparam int COEF_W          = 30;
    localparam int PROD_W          = 60;
    localparam int HALF_W          = 15;
    localparam int MUL_LAT         = 3;
    localparam int RED_LAT_DEFAULT = 3;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [HALF_W-1:0] half_t;

    // S set (modulus_sel = 0)
    localparam coef_t MOD_S0 = 30'd1068564481;
    localparam coef_t MOD_S1 = 30'd1068433409;
    localparam coef_t MOD_S2 = 30'd1068236801;
    localparam coef_t MOD_S3 = 30'd1065811969;
    localparam coef_t MOD_S4 = 30'd1065484289;
    localparam coef_t MOD_S5 = 30'd1064697857;

    // L set (modulus_sel = 1)
    localparam coef_t MOD_L0 = 30'd1073479681;
    localparam coef_t MOD_L1 = 30'd1072496641;
    localparam coef_t MOD_L2 = 30'd1071513601;
    localparam coef_t MOD_L3 = 30'd1070727169;
    localparam coef_t MOD_L4 = 30'd1070268417;
    localparam coef_t MOD_L5 = 30'd1069219841;

endpackage

// File: rtl/mult30x30_pipeline_mult15x15_reg.sv
// Unsigned 15x15 multiplier with a registered 30-bit product; one DSP slice.
module mult15x15_reg
    import mult30x30_pipeline_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};
        end
    end

endmodule

// File: rtl/mult30x30_pipeline.sv
// Three-stage 30x30 unsigned multiplier with a valid/sel/tag sideband delayed
// to line up with the downstream reducer's registered output.
module mult30x30_pipeline
    import mult30x30_pipeline_pkg::*;
#(
    parameter int TAG_W   = 8,
    parameter int RED_LAT = RED_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [COEF_W-1:0] in_a,
    input  logic [COEF_W-1:0] in_b,
    input  logic              in_sel,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [PROD_W-1:0] prod,
    output logic              prod_sel,
    output logic              prod_valid,
    output logic              res_valid,
    output logic              res_sel,
    output logic [TAG_W-1:0]  res_tag
);

    localparam int SB_DEPTH = MUL_LAT + RED_LAT;
    localparam int SB_W     = TAG_W + 2;

    // Valid-only handshake: there is no backpressure. A slot whose valid bit is
    // set carries a real operation; data and sideband shift every en=1 cycle
    // regardless, so valid is purely a qualifier.

    logic [COEF_W-1:0]   a_q;
    logic [COEF_W-1:0]   b_q;
    logic [2*HALF_W-1:0] pp_hh;
    logic [2*HALF_W-1:0] pp_hl;
    logic [2*HALF_W-1:0] pp_lh;
    logic [2*HALF_W-1:0] pp_ll;
    logic [2*HALF_W:0]   mid_sum;
    logic [PROD_W-1:0]   prod_q;
    logic [SB_W-1:0]     sb_q [SB_DEPTH];

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (en) begin
            a_q <= in_a;
            b_q <= in_b;
        end
    end

    // Stage 2: four registered partial products
    mult15x15_reg u_mul_hh (.clk(clk), .rst(rst), .en(en),
        .a(a_q[COEF_W-1:HALF_W]), .b(b_q[COEF_W-1:HALF_W]), .p(pp_hh));
    mult15x15_reg u_mul_hl (.clk(clk), .rst(rst), .en(en),
        .a(a_q[COEF_W-1:HALF_W]), .b(b_q[HALF_W-1:0]), .p(pp_hl));
    mult15x15_reg u_mul_lh (.clk(clk), .rst(rst), .en(en),
        .a(a_q[HALF_W-1:0]), .b(b_q[COEF_W-1:HALF_W]), .p(pp_lh));
    mult15x15_reg u_mul_ll (.clk(clk), .rst(rst), .en(en),
        .a(a_q[HALF_W-1:0]), .b(b_q[HALF_W-1:0]), .p(pp_ll));

    // Stage 3: recombine; the 60-bit sum cannot overflow for 30-bit operands
    always_comb begin
        mid_sum = {1'b0, pp_hl} + {1'b0, pp_lh};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else if (en) begin
            prod_q <= {pp_hh, {(2*HALF_W){1'b0}}}
                    + {{(PROD_W-3*HALF_W-1){1'b0}}, mid_sum, {HALF_W{1'b0}}}
                    + {{(PROD_W-2*HALF_W){1'b0}}, pp_ll};
        end
    end

    // Sideband {valid, sel, tag}; stage MUL_LAT-1 aligns with prod_q
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (en) begin
            sb_q[0] <= {in_valid, in_sel, in_tag};
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    assign prod       = prod_q;
    assign prod_valid = sb_q[MUL_LAT-1][SB_W-1];
    assign prod_sel   = sb_q[MUL_LAT-1][TAG_W];
    assign res_valid  = sb_q[SB_DEPTH-1][SB_W-1];
    assign res_sel    = sb_q[SB_DEPTH-1][TAG_W];
    assign res_tag    = sb_q[SB_DEPTH-1][TAG_W-1:0];

endmodule

// File: tb/tb_mult30x30_pipeline.sv
// Directed self-checking bench for mult30x30_pipeline: reset, products,
// sideband alignment, back-to-back streaming, mid-flight reset, stall, bubbles.
module tb_mult30x30_pipeline;
    import mult30x30_pipeline_pkg::*;

    localparam int TAG_W = 8;
    localparam int N_B2B = 1000;

    logic              clk;
    logic              rst;
    logic              en;
    logic              in_valid;
    logic [COEF_W-1:0] in_a;
    logic [COEF_W-1:0] in_b;
    logic              in_sel;
    logic [TAG_W-1:0]  in_tag;
    logic [PROD_W-1:0] prod;
    logic              prod_sel;
    logic              prod_valid;
    logic              res_valid;
    logic              res_sel;
    logic [TAG_W-1:0]  res_tag;

    int n_cmp;
    int n_err;

    logic [COEF_W-1:0] va [N_B2B];
    logic [COEF_W-1:0] vb [N_B2B];
    logic              vs [N_B2B];
    logic [TAG_W-1:0]  vt [N_B2B];
    logic [PROD_W-1:0] vp [N_B2B];

    mult30x30_pipeline #(.TAG_W(TAG_W), .RED_LAT(3)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_tag(in_tag),
        .prod(prod), .prod_sel(prod_sel), .prod_valid(prod_valid),
        .res_valid(res_valid), .res_sel(res_sel), .res_tag(res_tag)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic drive(input logic v, input logic [COEF_W-1:0] a,
                         input logic [COEF_W-1:0] b, input logic s,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sel   = s;
        in_tag   = t;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issues ops 0..n-1 back to back from the vector tables and checks both ends.
    task automatic run_stream(input string name, input int n);
        for (int c = 0; c < n + 6; c++) begin
            if (c < n) drive(1'b1, va[c], vb[c], vs[c], vt[c]);
            else       idle();
            step();
            if (c + 1 - 3 >= 0 && c + 1 - 3 < n) begin
                n_cmp++;
                if ({prod_valid, prod_sel, prod} !== {1'b1, vs[c-2], vp[c-2]}) begin
                    n_err++;
                    $display("FAIL %s_prod op=%0d got v=%b s=%b p=%h exp v=1 s=%b p=%h",
                             name, c - 2, prod_valid, prod_sel, prod, vs[c-2], vp[c-2]);
                end
            end
            if (c + 1 - 6 >= 0 && c + 1 - 6 < n) begin
                n_cmp++;
                if ({res_valid, res_sel, res_tag} !== {1'b1, vs[c-5], vt[c-5]}) begin
                    n_err++;
                    $display("FAIL %s_res op=%0d got v=%b s=%b t=%h exp v=1 s=%b t=%h",
                             name, c - 5, res_valid, res_sel, res_tag, vs[c-5], vt[c-5]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b1, 30'd3, 30'd5, 1'b1, 8'h55);
        step();
        step();
        n_cmp++;
        if ({prod, prod_valid, prod_sel, res_valid, res_sel, res_tag} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got p=%h pv=%b ps=%b rv=%b rs=%b rt=%h exp all 0",
                     prod, prod_valid, prod_sel, res_valid, res_sel, res_tag);
        end
        rst = 1'b0;
        idle();
        // the op presented during reset must never appear
        for (int c = 1; c <= 8; c++) begin
            step();
            n_cmp++;
            if ({prod_valid, res_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_drop cyc=%0d got pv=%b rv=%b exp 0 0",
                         c, prod_valid, res_valid);
            end
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 30'd3, 30'd5, 1'b0, 8'h11);
        for (int c = 1; c <= 7; c++) begin
            step();
            idle();
            n_cmp++;
            if (c == 3) begin
                if ({prod_valid, prod_sel, prod} !== {1'b1, 1'b0, 60'd15}) begin
                    n_err++;
                    $display("FAIL basic_prod got v=%b s=%b p=%0d exp v=1 s=0 p=15",
                             prod_valid, prod_sel, prod);
                end
            end else if (prod_valid !== 1'b0) begin
                n_err++;
                $display("FAIL basic_prod_idle cyc=%0d got v=%b exp 0", c, prod_valid);
            end
            n_cmp++;
            if (c == 6) begin
                if ({res_valid, res_sel, res_tag} !== {1'b1, 1'b0, 8'h11}) begin
                    n_err++;
                    $display("FAIL basic_res got v=%b s=%b t=%h exp v=1 s=0 t=11",
                             res_valid, res_sel, res_tag);
                end
            end else if (res_valid !== 1'b0) begin
                n_err++;
                $display("FAIL basic_res_idle cyc=%0d got v=%b exp 0", c, res_valid);
            end
        end
    endtask

    task automatic test_directed();
        va[0] = 30'h3FFFFFFF; vb[0] = 30'h3FFFFFFF; vs[0] = 1'b1; vt[0] = 8'h22;
        vp[0] = 60'h0FFF_FFFF_8000_0001;
        va[1] = 30'd12345;    vb[1] = 30'd67890;    vs[1] = 1'b0; vt[1] = 8'h23;
        vp[1] = 60'd838102050;
        va[2] = 30'h3FFF8000; vb[2] = 30'h00007FFF; vs[2] = 1'b1; vt[2] = 8'h24;
        vp[2] = 60'h1FFF_8000_8000;
        va[3] = 30'd0;        vb[3] = 30'h3FFFFFFF; vs[3] = 1'b0; vt[3] = 8'h25;
        vp[3] = 60'd0;
        va[4] = 30'h00008000; vb[4] = 30'h3FFFFFFF; vs[4] = 1'b1; vt[4] = 8'h26;
        vp[4] = 60'h1FFF_FFFF_8000;
        va[5] = 30'd1;        vb[5] = 30'd1;        vs[5] = 1'b0; vt[5] = 8'h27;
        vp[5] = 60'd1;
        run_stream("directed", 6);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < N_B2B; i++) begin
            va[i] = COEF_W'($urandom_range(32'h3FFF_FFFF, 0));
            vb[i] = COEF_W'($urandom_range(32'h3FFF_FFFF, 0));
            vs[i] = 1'($urandom_range(1, 0));
            vt[i] = TAG_W'(i);
            vp[i] = {30'b0, va[i]} * {30'b0, vb[i]};
        end
        run_stream("b2b", N_B2B);
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 13; c++) begin
            if (c < 3)       drive(1'b1, 30'd100 + 30'(c), 30'd7, 1'b1, 8'hA0 + 8'(c));
            else if (c == 5) drive(1'b1, 30'd7, 30'd9, 1'b1, 8'hB5);
            else             idle();
            rst = (c == 3);
            step();
            rst = 1'b0;
            if (c + 1 >= 4) begin
                n_cmp++;
                if (c + 1 == 8) begin
                    if ({prod_valid, prod_sel, prod} !== {1'b1, 1'b1, 60'd63}) begin
                        n_err++;
                        $display("FAIL rstmid_prod got v=%b s=%b p=%0d exp v=1 s=1 p=63",
                                 prod_valid, prod_sel, prod);
                    end
                end else if (prod_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_prod_stale cyc=%0d got v=%b exp 0", c + 1, prod_valid);
                end
                n_cmp++;
                if (c + 1 == 11) begin
                    if ({res_valid, res_sel, res_tag} !== {1'b1, 1'b1, 8'hB5}) begin
                        n_err++;
                        $display("FAIL rstmid_res got v=%b s=%b t=%h exp v=1 s=1 t=b5",
                                 res_valid, res_sel, res_tag);
                    end
                end else if ({res_valid, res_tag} !== 9'd0) begin
                    n_err++;
                    $display("FAIL rstmid_res_stale cyc=%0d got v=%b t=%h exp v=0 t=00",
                             c + 1, res_valid, res_tag);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [PROD_W-1:0] exp_p;
        for (int c = 0; c < 13; c++) begin
            if (c == 0)      drive(1'b1, 30'd1000, 30'd3000, 1'b1, 8'hC0);
            else if (c == 1) drive(1'b1, 30'h3FFFFFFF, 30'd2, 1'b0, 8'hC1);
            else             idle();
            en = !(c >= 2 && c <= 5);
            step();
            exp_p = (c + 1 == 7) ? 60'd3000000 : (c + 1 == 8) ? 60'h7FFFFFFE : 60'd0;
            n_cmp++;
            if ({prod_valid, prod} !== {(c + 1 == 7 || c + 1 == 8), exp_p}) begin
                n_err++;
                $display("FAIL stall_prod cyc=%0d got v=%b p=%h exp v=%b p=%h",
                         c + 1, prod_valid, prod, (c + 1 == 7 || c + 1 == 8), exp_p);
            end
            n_cmp++;
            if ({res_valid, res_sel, res_tag} !==
                ((c + 1 == 10) ? {1'b1, 1'b1, 8'hC0} :
                 (c + 1 == 11) ? {1'b1, 1'b0, 8'hC1} : 10'd0)) begin
                n_err++;
                $display("FAIL stall_res cyc=%0d got v=%b s=%b t=%h", c + 1,
                         res_valid, res_sel, res_tag);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_alternating();
        for (int c = 0; c < 17; c++) begin
            if (c < 10) drive(c % 2 == 0, 30'h8000, 30'h8000, 1'b0, TAG_W'(c));
            else        idle();
            step();
            if (c + 1 - 3 >= 0 && c + 1 - 3 < 10) begin
                n_cmp++;
                if ({prod_valid, prod} !== {((c - 2) % 2 == 0), 60'h4000_0000}) begin
                    n_err++;
                    $display("FAIL alt_prod slot=%0d got v=%b p=%h exp v=%b p=40000000",
                             c - 2, prod_valid, prod, ((c - 2) % 2 == 0));
                end
            end
            if (c + 1 - 6 >= 0 && c + 1 - 6 < 10) begin
                n_cmp++;
                if ({res_valid, res_tag} !== {((c - 5) % 2 == 0), TAG_W'(c - 5)}) begin
                    n_err++;
                    $display("FAIL alt_res slot=%0d got v=%b t=%h exp v=%b t=%h",
                             c - 5, res_valid, res_tag, ((c - 5) % 2 == 0), TAG_W'(c - 5));
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_stall();
        test_alternating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
